pfd_tdc_lock: RTL and testbench

//  Sampled digital phase-frequency detector with a time-to-digital error output and a lock detector.

---
 rtl/pfd_pkg.sv | 23 ++
 rtl/pfd_edge_sync.sv | 32 +++
 rtl/pfd_tdc_lock.sv | 184 ++++++++++++++++++
 tb/tb_pfd_tdc_lock.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pfd_pkg.sv
// Shared types and constants for the sampled PFD / TDC / lock detector.
// State encoding, error saturation limit and sign/direction conventions live here.
package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LEAD_REF = 2'd1,
    LEAD_FB  = 2'd2
  } pfd_state_e;

  // Negate flag applied to the measured magnitude: positive error means ref leads.
  localparam logic SIGN_REF_LEAD = 1'b0;
  localparam logic SIGN_FB_LEAD  = 1'b1;

  // Slip direction: which input produced the repeated edge.
  localparam logic SLIP_DIR_REF = 1'b1;
  localparam logic SLIP_DIR_FB  = 1'b0;

  function automatic int err_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// Multi-flop synchroniser for an asynchronous clock input followed by a
// registered rising-edge strobe (SYNC_STAGES+1 clk after the pin edge).
module pfd_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;

  // NOTE: every stage is cleared by the async reset so no phantom edge appears after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the shift chain a true chain of flops.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/pfd_tdc_lock.sv
// Sampled digital PFD with signed phase-error TDC and lock detector.
// Optional cycle-slip detection is enabled by defining PFD_SLIP_DETECT_EN.
module pfd_tdc_lock
  import pfd_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic                    err_valid,
  output logic signed [ERR_W-1:0] err_value,
  output logic                    locked,
  output logic                    slip,
  output logic                    slip_dir
);

  localparam int                CNT_W     = ERR_W - 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(err_max(ERR_W));
  localparam logic [CNT_W-1:0]  TOL       = CNT_W'(LOCK_TOL);
  localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_COUNT);

  logic ref_e, fb_e;

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (ref_in),
    .edge_o (ref_e)
  );

  pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (fb_in),
    .edge_o (fb_e)
  );

  pfd_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [GOOD_W-1:0]        good_q, good_d;
  logic                     locked_q, locked_d;
  logic                     err_valid_q, err_valid_d;
  logic signed [ERR_W-1:0]  err_value_q, err_value_d;
  logic                     slip_q, slip_d;
  logic                     slip_dir_q, slip_dir_d;
  logic                     meas_valid, meas_neg;
  logic [CNT_W-1:0]         meas_mag;

  // The completing edge counts as one more cycle, so the magnitude is the saturated increment.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    good_d      = good_q;
    locked_d    = locked_q;
    err_valid_d = 1'b0;
    err_value_d = err_value_q;
    slip_d      = 1'b0;
    slip_dir_d  = slip_dir_q;
    meas_valid  = 1'b0;
    meas_neg    = SIGN_REF_LEAD;
    meas_mag    = '0;

    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      good_d   = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ref_e && fb_e) begin
            meas_valid = 1'b1;
          end else if (ref_e) begin
            state_d = LEAD_REF;
            cnt_d   = '0;
          end else if (fb_e) begin
            state_d = LEAD_FB;
            cnt_d   = '0;
          end
        end
        LEAD_REF: begin
          if (fb_e) begin
            meas_valid = 1'b1;
            meas_neg   = SIGN_REF_LEAD;
            meas_mag   = cnt_inc;
            state_d    = ref_e ? LEAD_REF : IDLE;
            cnt_d      = '0;
          end else if (ref_e) begin
`ifdef PFD_SLIP_DETECT_EN
            slip_d     = 1'b1;
            slip_dir_d = SLIP_DIR_REF;
            good_d     = '0;
            locked_d   = 1'b0;
            cnt_d      = '0;
`else
            cnt_d      = cnt_inc;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LEAD_FB: begin
          if (ref_e) begin
            meas_valid = 1'b1;
            meas_neg   = SIGN_FB_LEAD;
            meas_mag   = cnt_inc;
            state_d    = fb_e ? LEAD_FB : IDLE;
            cnt_d      = '0;
          end else if (fb_e) begin
`ifdef PFD_SLIP_DETECT_EN
            slip_d     = 1'b1;
            slip_dir_d = SLIP_DIR_FB;
            good_d     = '0;
            locked_d   = 1'b0;
            cnt_d      = '0;
`else
            cnt_d      = cnt_inc;
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      if (meas_valid) begin
        err_valid_d = 1'b1;
        err_value_d = meas_neg ? -$signed({1'b0, meas_mag}) : $signed({1'b0, meas_mag});
        if (meas_mag <= TOL) begin
          good_d = (good_q == GOOD_FULL) ? GOOD_FULL : good_q + 1'b1;
        end else begin
          good_d = '0;
        end
        locked_d = (good_d == GOOD_FULL);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      good_q      <= '0;
      locked_q    <= 1'b0;
      err_valid_q <= 1'b0;
      err_value_q <= '0;
      slip_q      <= 1'b0;
      slip_dir_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      locked_q    <= locked_d;
      err_valid_q <= err_valid_d;
      err_value_q <= err_value_d;
      slip_q      <= slip_d;
      slip_dir_q  <= slip_dir_d;
    end
  end

  assign up        = (state_q == LEAD_REF);
  assign dn        = (state_q == LEAD_FB);
  assign err_valid = err_valid_q;
  assign err_value = err_value_q;
  assign locked    = locked_q;
  assign slip      = slip_q;
  assign slip_dir  = slip_dir_q;

endmodule

// File: tb/tb_pfd_tdc_lock.sv
// Directed, table-driven bench for pfd_tdc_lock (clk 1 GHz).
// Optional slip checks follow PFD_SLIP_DETECT_EN.
`timescale 1ns/100ps
module tb_pfd_tdc_lock;

  localparam int ERR_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    ref_in;
  logic                    fb_in;
  logic                    up, dn, err_valid, locked, slip, slip_dir;
  logic signed [ERR_W-1:0] err_value;

  pfd_tdc_lock #(
    .ERR_W(ERR_W), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_COUNT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .up        (up),
    .dn        (dn),
    .err_valid (err_valid),
    .err_value (err_value),
    .locked    (locked),
    .slip      (slip),
    .slip_dir  (slip_dir)
  );

  always #0.5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Results of the most recent run_seq window.
  int n_valid, last_err, lock_at_valid, up_cyc, dn_cyc, both_cyc;
  int n_slip, slip_dir_seen, lock_at_slip;

  function automatic bit pulse(input int c, input int at);
    return (at >= 0) && (c >= at) && (c < at + 30);
  endfunction

  // Drives 30-cycle pin pulses starting at the given cycle offsets (-1 = none),
  // sampling outputs on each falling edge before updating the pins.
  task automatic run_seq(input int ref_at, input int ref2_at, input int fb_at, input int len);
    n_valid = 0; last_err = 0; lock_at_valid = 0; up_cyc = 0; dn_cyc = 0; both_cyc = 0;
    n_slip = 0; slip_dir_seen = 0; lock_at_slip = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (err_valid) begin
        n_valid++;
        last_err      = int'(err_value);
        lock_at_valid = int'(locked);
      end
      if (slip) begin
        n_slip++;
        slip_dir_seen = int'(slip_dir);
        lock_at_slip  = int'(locked);
      end
      up_cyc   += int'(up);
      dn_cyc   += int'(dn);
      both_cyc += int'(up & dn);
      ref_in = pulse(c, ref_at) || pulse(c, ref2_at);
      fb_in  = pulse(c, fb_at);
    end
  endtask

  task automatic run_pair(input int delta);
    run_seq((delta >= 0) ? 0 : -delta, -1, (delta >= 0) ? delta : 0, 50);
  endtask

  task automatic wait_up(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = up;
    end
    check(name, int'(seen), 1);
  endtask

  typedef struct {
    int delta;
    int exp_err;
    int exp_lock;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0] = '{ 5,  5, 0};
    vecs[1] = '{-3, -3, 0};
    begin
      int seq [16] = '{0, 1, -1, 2, -2, 0, 1, -1, 2, -2, 0, 1, -1, 2, -2, 1};
      for (int i = 0; i < 16; i++) vecs[2 + i] = '{seq[i], seq[i], (i == 15) ? 1 : 0};
    end
    vecs[18] = '{3, 3, 0};

    rst = 1'b1; enable = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({up, dn, err_valid, locked, slip, slip_dir}), 0);
    check("reset_err_value", int'(err_value), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_reset", int'({up, dn, err_valid, locked}), 0);

    foreach (vecs[i]) begin
      run_pair(vecs[i].delta);
      check($sformatf("v%0d_valid_count", i), n_valid, 1);
      check($sformatf("v%0d_err_value", i), last_err, vecs[i].exp_err);
      check($sformatf("v%0d_locked", i), lock_at_valid, vecs[i].exp_lock);
      check($sformatf("v%0d_up_cycles", i), up_cyc, (vecs[i].delta > 0) ? vecs[i].delta : 0);
      check($sformatf("v%0d_dn_cycles", i), dn_cyc, (vecs[i].delta < 0) ? -vecs[i].delta : 0);
      check($sformatf("v%0d_up_dn_both", i), both_cyc, 0);
    end

    // Saturation: fb arrives 200 clk after ref.
    run_seq(0, -1, 200, 240);
    check("sat_valid_count", n_valid, 1);
    check("sat_err_value", last_err, 127);
    check("sat_up_cycles", up_cyc, 200);

    // Relock, then a repeated ref edge before fb.
    for (int i = 0; i < 16; i++) run_pair(0);
    check("relock_locked", int'(locked), 1);
    run_seq(0, 40, 60, 100);
    check("repeat_valid_count", n_valid, 1);
`ifdef PFD_SLIP_DETECT_EN
    check("slip_count", n_slip, 1);
    check("slip_dir", slip_dir_seen, 1);
    check("slip_locked", lock_at_slip, 0);
    check("slip_err_value", last_err, 20);
`else
    check("noslip_count", n_slip, 0);
    check("noslip_err_value", last_err, 60);
`endif
    check("repeat_locked_after", lock_at_valid, 0);

    // Asynchronous reset while a measurement is pending.
    @(negedge clk); ref_in = 1'b1;
    wait_up("rst_up_before");
    #0.2 rst = 1'b1;
    #0.1 check("rst_async_up", int'(up), 0);
    @(negedge clk); ref_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_seq(-1, -1, -1, 20);
    check("rst_no_valid", n_valid, 0);
    check("rst_no_up", up_cyc, 0);
    run_pair(4);
    check("rst_next_err", last_err, 4);
    check("rst_next_valid", n_valid, 1);

    // Same sequence with enable dropped instead of reset.
    @(negedge clk); ref_in = 1'b1;
    wait_up("en_up_before");
    enable = 1'b0;
    run_seq(-1, -1, 2, 40);
    check("en_no_valid", n_valid, 0);
    check("en_no_up", up_cyc, 0);
    check("en_locked", int'(locked), 0);
    enable = 1'b1;
    run_pair(-2);
    check("en_next_err", last_err, -2);
    check("en_next_dn", dn_cyc, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
